basic_shift_select: RTL and testbench



---
 rtl/basic_shift_select_pkg.sv | 18 +
 rtl/shift_select_stage.sv | 30 +++
 rtl/basic_shift_select.sv | 93 +++++++++
 tb/tb_basic_shift_select.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/basic_shift_select_pkg.sv
// Shared constants, mode encoding and count-width helper for basic_shift_select.
package basic_shift_select_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_DEPTH = 2;
  localparam int unsigned DEFAULT_INIT  = 0;

  typedef enum logic {
    SHIFT  = 1'b0,
    RECIRC = 1'b1
  } mode_e;

  // Bits needed to hold a fill count from 0 up to and including depth.
  function automatic int unsigned count_width(input int unsigned depth);
    return (depth + 1 <= 2) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_select_stage.sv
// One chain stage: WIDTH-bit register with sync reset, enable and a
// previous-stage / feedback input mux.
module shift_select_stage
  import basic_shift_select_pkg::*;
#(
  parameter int unsigned      WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(DEFAULT_INIT)
) (
  input  logic             real_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] d_prev,
  input  logic [WIDTH-1:0] d_fb,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] d;

  always_comb begin
    d = d_prev;
    if (sel == RECIRC) d = d_fb;
  end

  always_ff @(posedge real_clk) begin
    if (reset)   q <= INIT;
    else if (en) q <= d;
  end

endmodule

// File: rtl/basic_shift_select.sv
// DEPTH-stage delay line with shift/recirculate select, saturating fill count
// and O0/O1 tail/bypass swap. Define BASIC_SHIFT_SELECT_ROTATE_EN for rotate on S=1.
module basic_shift_select
  import basic_shift_select_pkg::*;
#(
  parameter int unsigned      WIDTH = DEFAULT_WIDTH,
  parameter int unsigned      DEPTH = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(DEFAULT_INIT)
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [WIDTH-1:0]                I,
  input  logic                            S,
  input  logic                            EN,
  output logic [WIDTH-1:0]                O0,
  output logic [WIDTH-1:0]                O1,
  output logic [WIDTH*DEPTH-1:0]          TAP,
  output logic [count_width(DEPTH)-1:0]   COUNT,
  output logic                            FULL
);

  localparam int unsigned     CW   = count_width(DEPTH);
  localparam logic [CW-1:0]   CMAX = CW'(DEPTH);

  logic [WIDTH-1:0] r [DEPTH];
  logic [WIDTH-1:0] tail;
  logic             stage_en;
  logic [CW-1:0]    count_q;

  assign tail = r[DEPTH-1];

`ifdef BASIC_SHIFT_SELECT_ROTATE_EN
  assign stage_en = EN;
`else
  // Hold build: recirculate means freeze, so gate the stage enables instead.
  assign stage_en = EN && (S == SHIFT);
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d_prev;
    logic [WIDTH-1:0] d_fb;

    // Only stage 0 has a distinct feedback leg; later stages always take r[k-1].
    if (k == 0) begin : g_head
      assign d_prev = I;
      assign d_fb   = tail;
    end else begin : g_body
      assign d_prev = r[k-1];
      assign d_fb   = r[k-1];
    end

    shift_select_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .real_clk (CLK),
      .reset    (RESET),
      .en       (stage_en),
      .sel      (S),
      .d_prev   (d_prev),
      .d_fb     (d_fb),
      .q        (r[k])
    );
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else if (EN && (S == SHIFT) && (count_q != CMAX)) begin
      count_q <= count_q + CW'(1);
    end
  end

  always_comb begin
    O0 = tail;
    O1 = I;
    if (S == RECIRC) begin
      O0 = I;
      O1 = tail;
    end
  end

  always_comb begin
    TAP = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      TAP[k*WIDTH +: WIDTH] = r[k];
    end
  end

  assign COUNT = count_q;
  assign FULL  = (count_q == CMAX);

endmodule

// File: tb/tb_basic_shift_select.sv
// Self-checking bench for basic_shift_select: DEPTH=2 and DEPTH=1 instances,
// directed table, hand-written DEPTH=1 sequence, randomized run against a queue model.
module tb_basic_shift_select;

`ifdef BASIC_SHIFT_SELECT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, s;
  logic [3:0] i;

  logic [3:0] o0_2, o1_2, o0_1, o1_1;
  logic [7:0] tap_2;
  logic [3:0] tap_1;
  logic [1:0] cnt_2;
  logic [0:0] cnt_1;
  logic       full_2, full_1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  basic_shift_select #(.WIDTH(4), .DEPTH(2), .INIT(4'h0)) dut2 (
    .CLK(clk), .RESET(rst), .I(i), .S(s), .EN(en),
    .O0(o0_2), .O1(o1_2), .TAP(tap_2), .COUNT(cnt_2), .FULL(full_2)
  );

  basic_shift_select #(.WIDTH(4), .DEPTH(1), .INIT(4'h0)) dut1 (
    .CLK(clk), .RESET(rst), .I(i), .S(s), .EN(en),
    .O0(o0_1), .O1(o1_1), .TAP(tap_1), .COUNT(cnt_1), .FULL(full_1)
  );

  // Reference model: q[0] is stage 0, the last element is the tail.
  logic [3:0] q2[$];
  logic [3:0] q1[$];
  int         c2, c1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(inout logic [3:0] q[$], inout int c, input int depth);
    logic [3:0] t;
    if (rst) begin
      q.delete();
      for (int k = 0; k < depth; k++) q.push_back(4'h0);
      c = 0;
    end else if (en) begin
      if (!s) begin
        q.push_front(i);
        t = q.pop_back();
        c = (c + 1 > depth) ? depth : c + 1;
      end else if (ROT) begin
        t = q.pop_back();
        q.push_front(t);
      end
    end
  endtask

  task automatic model_check();
    logic [7:0] t2;
    t2 = {q2[1], q2[0]};
    check("m2_tap",  32'(tap_2),  32'(t2));
    check("m2_cnt",  32'(cnt_2),  32'(c2));
    check("m2_full", 32'(full_2), 32'(c2 == 2));
    check("m2_o0",   32'(o0_2),   32'(s ? i : q2[1]));
    check("m2_o1",   32'(o1_2),   32'(s ? q2[1] : i));
    check("m1_tap",  32'(tap_1),  32'(q1[0]));
    check("m1_cnt",  32'(cnt_1),  32'(c1));
    check("m1_full", 32'(full_1), 32'(c1 == 1));
    check("m1_o0",   32'(o0_1),   32'(s ? i : q1[0]));
    check("m1_o1",   32'(o1_1),   32'(s ? q1[0] : i));
  endtask

  task automatic apply(input logic r_, input logic e_, input logic s_, input logic [3:0] i_);
    @(negedge clk);
    rst = r_; en = e_; s = s_; i = i_;
    @(posedge clk);
    model_step(q2, c2, 2);
    model_step(q1, c1, 1);
    #1;
    model_check();
  endtask

  typedef struct {
    logic       rst, en, s;
    logic [3:0] i;
    logic [7:0] tap;
    logic [1:0] cnt;
    logic       full;
  } vec_t;

  vec_t tbl[12];

  initial begin
    rst = 1'b1; en = 1'b0; s = 1'b0; i = 4'h0;

    tbl[0]  = '{1, 1, 0, 4'hF, 8'h00, 2'd0, 0};
    tbl[1]  = '{0, 1, 0, 4'h3, 8'h03, 2'd1, 0};
    tbl[2]  = '{0, 1, 0, 4'h5, 8'h35, 2'd2, 1};
    tbl[3]  = '{0, 0, 0, 4'hA, 8'h35, 2'd2, 1};
    tbl[4]  = '{0, 0, 1, 4'h5, 8'h35, 2'd2, 1};
    tbl[5]  = '{0, 0, 0, 4'hC, 8'h35, 2'd2, 1};
    tbl[6]  = '{0, 1, 1, 4'hE, ROT ? 8'h53 : 8'h35, 2'd2, 1};
    tbl[7]  = '{0, 1, 0, 4'h7, ROT ? 8'h37 : 8'h57, 2'd2, 1};
    tbl[8]  = '{1, 0, 0, 4'h0, 8'h00, 2'd0, 0};
    tbl[9]  = '{0, 1, 0, 4'h9, 8'h09, 2'd1, 0};
    tbl[10] = '{1, 1, 0, 4'hB, 8'h00, 2'd0, 0};
    tbl[11] = '{0, 1, 0, 4'h2, 8'h02, 2'd1, 0};

    for (int n = 0; n < 12; n++) begin
      apply(tbl[n].rst, tbl[n].en, tbl[n].s, tbl[n].i);
      check($sformatf("tbl%0d_tap", n),  32'(tap_2),  32'(tbl[n].tap));
      check($sformatf("tbl%0d_cnt", n),  32'(cnt_2),  32'(tbl[n].cnt));
      check($sformatf("tbl%0d_full", n), 32'(full_2), 32'(tbl[n].full));
      if (n == 0) check("reset_o1_bypass", 32'(o1_2), 32'h0000000F);
      if (n == 2) check("fill_o0_tail",    32'(o0_2), 32'h00000003);
      if (n == 6) begin
        check("recirc_o0_is_i",  32'(o0_2), 32'h0000000E);
        check("recirc_o1_is_r1", 32'(o1_2), ROT ? 32'h00000005 : 32'h00000003);
      end
    end

    // DEPTH=1: shift loads stage 0 directly; rotate leaves it unchanged.
    apply(1, 0, 0, 4'h0);
    apply(0, 1, 0, 4'hA);
    check("d1_o0_after_shift", 32'(o0_1),   32'h0000000A);
    check("d1_full",           32'(full_1), 32'h00000001);
    apply(0, 1, 1, 4'h3);
    check("d1_rotate_tap",     32'(tap_1),  32'h0000000A);
    check("d1_rotate_o1",      32'(o1_1),   32'h0000000A);
    check("d1_rotate_o0",      32'(o0_1),   32'h00000003);

    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
